// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed hex display scanner.
package display_pkg;

    localparam int DIGITS_MAX = 8;
    localparam int NIBBLE_W   = 4;

    // All anodes high: every digit dark on the common-anode array.
    localparam logic [DIGITS_MAX-1:0] AN_OFF = '1;

    function automatic int idx_width(input int d);
        return (d <= 1) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// Value/strobe inputs and decoder/anode outputs of the display scanner.
interface display_scan_if #(
    parameter int DIGITS = 4
);
    import display_pkg::*;

    logic [NIBBLE_W*DIGITS-1:0] value;
    logic                       load;
    logic [NIBBLE_W-1:0]        n;
    logic [DIGITS-1:0]          an;
    logic                       frame;

    modport master (output value, load, input n, an, frame);
    modport slave  (input value, load, output n, an, frame);

endinterface

// File: rtl/scan_tick.sv
// Digit-slot prescaler: pulses tick once every TICK_DIV clock cycles.
module scan_tick #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] pcnt;

    assign tick = (pcnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed hex display scanner with frame-aligned double buffering.
// Define DISPLAY_LZ_BLANK_EN to blank leading zero digits.
module display_scan
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000
) (
    input  logic           clk,
    input  logic           rst,
    display_scan_if.slave  bus
);

    localparam int IW = idx_width(DIGITS);
    localparam int VW = NIBBLE_W * DIGITS;

    logic                tick;
    logic                wrap;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_next;
    logic [VW-1:0]       act;
    logic [VW-1:0]       act_next;
    logic [VW-1:0]       pend;
    logic [VW-1:0]       pend_next;
    logic                pv;
    logic                pv_next;
    logic [DIGITS-1:0]   an_q;
    logic [DIGITS-1:0]   an_next;
    logic [NIBBLE_W-1:0] n_q;
    logic [NIBBLE_W-1:0] n_next;
    logic                frame_q;
`ifdef DISPLAY_LZ_BLANK_EN
    logic                lead_zero;
`endif

    scan_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A load landing on the frame boundary bypasses pend so it is never lost
    // and still appears from digit 0 of the very next frame.
    always_comb begin
        wrap      = tick && (idx == IW'(DIGITS - 1));
        idx_next  = idx;
        pend_next = pend;
        act_next  = act;
        pv_next   = pv;

        if (tick) begin
            idx_next = wrap ? '0 : idx + IW'(1);
        end
        if (bus.load) begin
            pend_next = bus.value;
        end
        if (wrap && bus.load) begin
            act_next = bus.value;
        end else if (wrap && pv) begin
            act_next = pend;
        end
        if (wrap) begin
            pv_next = 1'b0;
        end else if (bus.load) begin
            pv_next = 1'b1;
        end

        n_next  = act_next[NIBBLE_W*idx_next +: NIBBLE_W];
        an_next = ~(DIGITS'(1) << idx_next);

`ifdef DISPLAY_LZ_BLANK_EN
        lead_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx_next) && act_next[NIBBLE_W*k +: NIBBLE_W] != '0) begin
                lead_zero = 1'b0;
            end
        end
        if (idx_next != '0 && lead_zero) begin
            an_next = AN_OFF[DIGITS-1:0];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            act     <= '0;
            pend    <= '0;
            pv      <= 1'b0;
            an_q    <= AN_OFF[DIGITS-1:0];
            n_q     <= '0;
            frame_q <= 1'b0;
        end else begin
            idx     <= idx_next;
            act     <= act_next;
            pend    <= pend_next;
            pv      <= pv_next;
            an_q    <= an_next;
            n_q     <= n_next;
            frame_q <= wrap;
        end
    end

    assign bus.an    = an_q;
    assign bus.n     = n_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIGITS=4, TICK_DIV=4.
module tb_display_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    display_scan_if #(.DIGITS(4)) bus ();

    display_scan #(.DIGITS(4), .TICK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected anode pattern for digit slot d showing value v.
    function automatic logic [3:0] exp_an(input logic [15:0] v, input int d);
        logic [3:0] a;
        a = ~(4'b0001 << d);
`ifdef DISPLAY_LZ_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 16'h0) a = 4'b1111;
`endif
        return a;
    endfunction

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.frame === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_value(input logic [15:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic test_reset;
        bus.load  = 1'b0;
        bus.value = 16'h0;
        @(negedge clk);
        total++; if (bus.an !== 4'b1111) begin bad++; $display("[TB] FAIL reset_an got=%b want=1111", bus.an); end
        total++; if (bus.n !== 4'h0) begin bad++; $display("[TB] FAIL reset_n got=%h want=0", bus.n); end
        total++; if (bus.frame !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame got=%b want=0", bus.frame); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.an !== 4'b1110) begin bad++; $display("[TB] FAIL first_edge_an got=%b want=1110", bus.an); end
        total++; if (bus.n !== 4'h0) begin bad++; $display("[TB] FAIL first_edge_n got=%h want=0", bus.n); end
    endtask

    task automatic test_scan_order;
        bit ok;
        logic [15:0] v;
        v = 16'h1234;
        load_value(v);
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL scan_frame_timeout got=0 want=1"); end
        for (int c = 0; c < 16; c++) begin
            total++; if (bus.an !== exp_an(v, c / 4)) begin bad++; $display("[TB] FAIL scan_an c=%0d got=%b want=%b", c, bus.an, exp_an(v, c / 4)); end
            total++; if (bus.n !== v[4*(c/4) +: 4]) begin bad++; $display("[TB] FAIL scan_n c=%0d got=%h want=%h", c, bus.n, v[4*(c/4) +: 4]); end
            total++; if (bus.frame !== (c == 0)) begin bad++; $display("[TB] FAIL scan_frame c=%0d got=%b want=%b", c, bus.frame, (c == 0)); end
            @(negedge clk);
        end
        total++; if (bus.frame !== 1'b1) begin bad++; $display("[TB] FAIL scan_frame_period got=%b want=1", bus.frame); end
    endtask

    task automatic test_deferred;
        bit ok;
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL defer_frame_timeout got=0 want=1"); end
        repeat (4) @(negedge clk);
        total++; if (bus.an !== 4'b1101 || bus.n !== 4'h3) begin bad++; $display("[TB] FAIL defer_d1 got=%b/%h want=1101/3", bus.an, bus.n); end
        load_value(16'hABCD);
        repeat (3) @(negedge clk);
        total++; if (bus.an !== 4'b1011 || bus.n !== 4'h2) begin bad++; $display("[TB] FAIL defer_d2 got=%b/%h want=1011/2", bus.an, bus.n); end
        repeat (4) @(negedge clk);
        total++; if (bus.an !== 4'b0111 || bus.n !== 4'h1) begin bad++; $display("[TB] FAIL defer_d3 got=%b/%h want=0111/1", bus.an, bus.n); end
        repeat (4) @(negedge clk);
        total++; if (bus.frame !== 1'b1) begin bad++; $display("[TB] FAIL defer_frame got=%b want=1", bus.frame); end
        total++; if (bus.an !== 4'b1110 || bus.n !== 4'hD) begin bad++; $display("[TB] FAIL defer_new_d0 got=%b/%h want=1110/d", bus.an, bus.n); end
        repeat (4) @(negedge clk);
        total++; if (bus.n !== 4'hC) begin bad++; $display("[TB] FAIL defer_new_d1 got=%h want=c", bus.n); end
    endtask

    task automatic test_last_load;
        bit ok;
        wait_frame(ok);
        load_value(16'h1111);
        load_value(16'h2222);
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL last_frame_timeout got=0 want=1"); end
        for (int d = 0; d < 4; d++) begin
            total++; if (bus.n !== 4'h2 || bus.an !== exp_an(16'h2222, d)) begin bad++; $display("[TB] FAIL last_load d=%0d got=%b/%h want=%b/2", d, bus.an, bus.n, exp_an(16'h2222, d)); end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_wrap_collision;
        bit ok;
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL wrap_frame_timeout got=0 want=1"); end
        repeat (15) @(negedge clk);
        load_value(16'h5555);
        total++; if (bus.frame !== 1'b1) begin bad++; $display("[TB] FAIL wrap_frame got=%b want=1", bus.frame); end
        total++; if (dut.pv !== 1'b0) begin bad++; $display("[TB] FAIL wrap_pv got=%b want=0", dut.pv); end
        for (int d = 0; d < 4; d++) begin
            total++; if (bus.n !== 4'h5 || bus.an !== exp_an(16'h5555, d)) begin bad++; $display("[TB] FAIL wrap_load d=%0d got=%b/%h want=%b/5", d, bus.an, bus.n, exp_an(16'h5555, d)); end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        wait_frame(ok);
        repeat (8) @(negedge clk);
        total++; if (bus.an !== 4'b1011) begin bad++; $display("[TB] FAIL mid_before got=%b want=1011", bus.an); end
        #1 rst = 1'b1;
        #1;
        total++; if (bus.an !== 4'b1111) begin bad++; $display("[TB] FAIL mid_async_an got=%b want=1111", bus.an); end
        @(negedge clk);
        rst = 1'b0;
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL mid_frame_timeout got=0 want=1"); end
        for (int d = 0; d < 4; d++) begin
            total++; if (bus.n !== 4'h0 || bus.an !== exp_an(16'h0, d)) begin bad++; $display("[TB] FAIL mid_after d=%0d got=%b/%h want=%b/0", d, bus.an, bus.n, exp_an(16'h0, d)); end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_blanking;
        bit ok;
        logic [15:0] vals [2];
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
        for (int t = 0; t < 2; t++) begin
            load_value(vals[t]);
            wait_frame(ok);
            total++; if (!ok) begin bad++; $display("[TB] FAIL blank_frame_timeout got=0 want=1"); end
            for (int d = 0; d < 4; d++) begin
                total++; if (bus.an !== exp_an(vals[t], d)) begin bad++; $display("[TB] FAIL blank_an v=%h d=%0d got=%b want=%b", vals[t], d, bus.an, exp_an(vals[t], d)); end
                total++; if (bus.n !== vals[t][4*d +: 4]) begin bad++; $display("[TB] FAIL blank_n v=%h d=%0d got=%h want=%h", vals[t], d, bus.n, vals[t][4*d +: 4]); end
                repeat (4) @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_deferred();
        test_last_load();
        test_wrap_collision();
        test_reset_mid();
        test_blanking();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
